// File: rtl/sos_ctrl_pkg.sv
// Shared types and sizing helpers for the sos_cache front-end sequencer.
package sos_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int CELLS_X_DEF = 34;
  localparam int CELLS_Y_DEF = 34;
  localparam int N_DEF       = CELLS_X_DEF * CELLS_Y_DEF;

  // Counter width for a value range 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sos_cell_pos.sv
// Frame position tracker: idx/row/col counters advanced by push, plus window prediction.
module sos_cell_pos
  import sos_ctrl_pkg::*;
#(
  parameter int CELLS_X = CELLS_X_DEF,
  parameter int CELLS_Y = CELLS_Y_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  output logic win_o,
  output logic last_o
);

  localparam int N     = CELLS_X * CELLS_Y;
  localparam int IDX_W = cnt_w(N);
  localparam int COL_W = cnt_w(CELLS_X);
  localparam int ROW_W = cnt_w(CELLS_Y);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_X - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             last_row_cell;

  assign last_o        = (idx_q == IDX_LAST);
  assign last_row_cell = (col_q == COL_LAST);
  // A 3x3 window completes once two full rows and two columns precede this cell.
  assign win_o         = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    idx_d = last_o ? '0 : idx_q + 1'b1;
    col_d = last_row_cell ? '0 : col_q + 1'b1;
    row_d = row_q;
    if (last_o)             row_d = '0;
    else if (last_row_cell) row_d = row_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (push_i) begin
      idx_q <= idx_d;
      col_q <= idx_d == '0 ? '0 : col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sos_cache_ctrl.sv
// Frame sequencer / window-rate scheduler feeding sos_cache with exactly N pushes per frame.
// Optional SOS_CTRL_CHECK_EN: cross-checks predicted windows against the cache's window_valid.
module sos_cache_ctrl
  import sos_ctrl_pkg::*;
#(
  parameter int TOTAL_BIT_WIDTH = 35,
  parameter int CELLS_X         = CELLS_X_DEF,
  parameter int CELLS_Y         = CELLS_Y_DEF,
  parameter int WIN_GAP         = 3,
  parameter int DELAY           = 1
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [TOTAL_BIT_WIDTH-1:0] s_data,
  input  logic                       s_last,
  input  logic                       win_ready,
  input  logic                       window_valid,
  output logic                       sos_valid,
  output logic [TOTAL_BIT_WIDTH-1:0] sum_of_squares,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_long,
  output logic                       err_sync
);

  localparam int HO_W = cnt_w(WIN_GAP + 1);

  state_e                     state_q;
  logic [HO_W-1:0]            holdoff_q, holdoff_d;
  logic                       sos_valid_q;
  logic [TOTAL_BIT_WIDTH-1:0] sos_data_q;
  logic                       frame_done_q, err_short_q, err_long_q;

  logic                       pos_win, pos_last;
  logic                       push_ok, push;
  logic [TOTAL_BIT_WIDTH-1:0] push_data;

  // Registered outputs carry no modelled delay; DELAY is kept for interface compatibility.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  sos_cell_pos #(
    .CELLS_X (CELLS_X),
    .CELLS_Y (CELLS_Y)
  ) u_pos (
    .clk_i  (aclk),
    .rst_i  (arest),
    .push_i (push),
    .win_o  (pos_win),
    .last_o (pos_last)
  );

  // Only window-producing pushes are throttled; all others go unconditionally.
  assign push_ok = !pos_win || (win_ready && (holdoff_q == '0));

  always_comb begin
    s_ready   = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      ST_RUN: begin
        s_ready   = push_ok;
        push      = s_valid && push_ok;
        push_data = s_data;
      end
      ST_PAD:  push    = push_ok;
      ST_DROP: s_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    holdoff_d = holdoff_q;
    if (push && pos_win)       holdoff_d = HO_W'(WIN_GAP);
    else if (holdoff_q != '0)  holdoff_d = holdoff_q - 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      state_q      <= ST_RUN;
      holdoff_q    <= '0;
      sos_valid_q  <= 1'b0;
      sos_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      holdoff_q    <= holdoff_d;
      sos_valid_q  <= push;
      frame_done_q <= push && pos_last;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      if (push) sos_data_q <= push_data;
      case (state_q)
        ST_RUN: begin
          if (push && s_last && !pos_last) begin
            err_short_q <= 1'b1;
            state_q     <= ST_PAD;
          end else if (push && !s_last && pos_last) begin
            err_long_q  <= 1'b1;
            state_q     <= ST_DROP;
          end
        end
        ST_PAD:  if (push && pos_last)    state_q <= ST_RUN;
        ST_DROP: if (s_valid && s_last)   state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign sos_valid      = sos_valid_q;
  assign sum_of_squares = sos_data_q;
  assign frame_done     = frame_done_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

`ifdef SOS_CTRL_CHECK_EN
  // Prediction travels two stages to line up with the cache's window_valid.
  logic [1:0] pred_pipe_q;
  logic       err_sync_q;

  always_ff @(posedge aclk) begin
    if (arest) begin
      pred_pipe_q <= '0;
      err_sync_q  <= 1'b0;
    end else begin
      pred_pipe_q <= {pred_pipe_q[0], push && pos_win};
      err_sync_q  <= pred_pipe_q[1] != window_valid;
    end
  end

  assign err_sync = err_sync_q;
`else
  logic unused_window_valid;
  assign unused_window_valid = window_valid;
  assign err_sync            = 1'b0;
`endif

endmodule

// File: tb/tb_sos_cache_ctrl.sv
// Directed bench for sos_cache_ctrl with a small sos_cache window model and push scoreboard.
module tb_sos_cache_ctrl;

  localparam int W   = 35;
  localparam int CX  = 34;
  localparam int CY  = 34;
  localparam int N   = CX * CY;
  localparam int GAP = 3;
`ifdef SOS_CTRL_CHECK_EN
  localparam int SY_EXP = 1;
`else
  localparam int SY_EXP = 0;
`endif

  logic         aclk = 1'b0;
  logic         arest, s_valid, s_last, win_ready, s_ready;
  logic         window_valid, sos_valid, frame_done, err_short, err_long, err_sync;
  logic [W-1:0] s_data, sum_of_squares;

  int checks = 0, errors = 0, timeouts = 0;

  always #5 aclk = ~aclk;

  sos_cache_ctrl #(
    .TOTAL_BIT_WIDTH (W),
    .CELLS_X         (CX),
    .CELLS_Y         (CY),
    .WIN_GAP         (GAP),
    .DELAY           (1)
  ) dut (
    .aclk           (aclk),
    .arest          (arest),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .win_ready      (win_ready),
    .window_valid   (window_valid),
    .sos_valid      (sos_valid),
    .sum_of_squares (sum_of_squares),
    .frame_done     (frame_done),
    .err_short      (err_short),
    .err_long       (err_long),
    .err_sync       (err_sync)
  );

  // Cache model + scoreboard, evaluated on the falling edge.
  int   m_idx = 0, cyc_n = 0, push_cnt = 0, win_cnt = 0, zero_cnt = 0, data_bad = 0;
  int   fd_cnt = 0, fd_bad = 0, es_cnt = 0, es_idx = -1, el_cnt = 0, el_idx = -1, sy_cnt = 0;
  int   push_time [N];
  bit   pad_mode = 0;
  logic wv_pend = 1'b0, wv_q = 1'b0, spur = 1'b0;

  assign window_valid = wv_q | spur;

  always @(negedge aclk) begin
    int cur;
    cyc_n++;
    cur = m_idx;
    if (arest) begin
      m_idx   = 0;
      wv_pend = 1'b0;
      wv_q    = 1'b0;
    end else begin
      wv_q    = wv_pend;
      wv_pend = 1'b0;
      if (sos_valid) begin
        wv_pend = ((cur / CX) >= 2) && ((cur % CX) >= 2);
        if (wv_pend) win_cnt++;
        push_cnt++;
        push_time[cur] = cyc_n;
        if (pad_mode && cur > 500) begin
          if (sum_of_squares == '0) zero_cnt++;
          else data_bad++;
        end else if (sum_of_squares != W'(cur)) data_bad++;
        m_idx = (cur == N - 1) ? 0 : cur + 1;
      end
      if (frame_done) begin
        fd_cnt++;
        if (!sos_valid || cur != N - 1) fd_bad++;
      end
      if (err_short) begin es_cnt++; es_idx = sos_valid ? cur : -1; end
      if (err_long)  begin el_cnt++; el_idx = sos_valid ? cur : -1; end
      if (err_sync)  sy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  task automatic send(input int d, input bit last);
    bit rdy;
    rdy     = 1'b0;
    s_valid = 1'b1;
    s_data  = W'(d);
    s_last  = last;
    for (int k = 0; k < 200 && !rdy; k++) begin
      #1;
      rdy = s_ready;
      @(posedge aclk);
      #2;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!rdy) timeouts++;
  endtask

  // Counts beats accepted with win_ready low; leaves the first refused beat presented.
  task automatic stall(output int n);
    n         = 0;
    win_ready = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      s_valid = 1'b1;
      s_data  = W'(n);
      s_last  = 1'b0;
      #1;
      if (!s_ready) break;
      @(posedge aclk);
      #2;
      n++;
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_sos_valid"}, sos_valid, 0);
    check({pfx, "_sum"},       sum_of_squares, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_err_short"}, err_short, 0);
    check({pfx, "_err_long"},  err_long, 0);
    check({pfx, "_err_sync"},  err_sync, 0);
  endtask

  initial begin
    int n, base, k;
    arest = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; win_ready = 1'b1;
    repeat (3) cyc();
    check_outputs_zero("reset");
    arest = 1'b0;

    // Frame A: full ramp, consumer always ready
    for (int i = 0; i < N; i++) send(i, i == N - 1);
    repeat (5) cyc();
    check("a_pushes",   push_cnt, N);
    check("a_fd_cnt",   fd_cnt, 1);
    check("a_fd_bad",   fd_bad, 0);
    check("a_windows",  win_cnt, 1024);
    check("a_err_short", es_cnt, 0);
    check("a_err_long", el_cnt, 0);
    check("a_err_sync", sy_cnt, 0);

    // Frame B: win_ready low stalls at first window cell, then holdoff spacing
    stall(n);
    check("b_stall_at", n, 70);
    repeat (3) cyc();
    check("b_stall_ready", s_ready, 0);
    check("b_stall_pushes", push_cnt, N + 70);
    win_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    check("b_idx70_valid", sos_valid, 1);
    check("b_idx70_data",  sum_of_squares, 70);
    for (int i = 71; i < N; i++) send(i, i == N - 1);
    repeat (5) cyc();
    check("b_gap_70_71",   push_time[71]  - push_time[70],  GAP + 1);
    check("b_gap_100_101", push_time[101] - push_time[100], GAP + 1);
    check("b_gap_101_102", push_time[102] - push_time[101], 1);
    check("b_gap_102_103", push_time[103] - push_time[102], 1);
    check("b_fd_cnt", fd_cnt, 2);

    // Frame C: short frame, s_last at idx 500, padded with zeros
    pad_mode = 1;
    base     = push_cnt;
    for (int i = 0; i <= 500; i++) send(i, i == 500);
    s_valid = 1'b1; s_data = W'(12345); #1;
    check("c_pad_ready", s_ready, 0);
    s_valid = 1'b0;
    k = 0;
    while (fd_cnt < 3 && k < 5000) begin cyc(); k++; end
    repeat (3) cyc();
    pad_mode = 0;
    check("c_fd_cnt",    fd_cnt, 3);
    check("c_es_cnt",    es_cnt, 1);
    check("c_es_idx",    es_idx, 500);
    check("c_zero_push", zero_cnt, 655);
    check("c_frame_len", push_cnt - base, N);
    stall(n);
    check("c_next_idx0", n, 70);

    // Frame D: long frame, no s_last at idx N-1, 10 beats dropped
    win_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int i = 71; i < N; i++) send(i, 1'b0);
    repeat (3) cyc();
    check("d_el_cnt", el_cnt, 1);
    check("d_el_idx", el_idx, N - 1);
    check("d_fd_cnt", fd_cnt, 4);
    check("d_fd_bad", fd_bad, 0);
    base = push_cnt;
    for (int j = 0; j < 10; j++) begin
      s_valid = 1'b1; s_data = W'(j); s_last = (j == 9); #1;
      check("d_drop_ready", s_ready, 1);
      cyc();
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) cyc();
    check("d_drop_pushes", push_cnt, base);
    stall(n);
    check("d_next_idx0", n, 70);

    // Reset mid-frame at idx 300
    win_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int i = 71; i <= 300; i++) send(i, 1'b0);
    arest = 1'b1;
    cyc();
    check_outputs_zero("midrst");
    arest = 1'b0;
    stall(n);
    check("rst_next_idx0", n, 70);
    s_valid = 1'b0;
    repeat (4) cyc();
    check("sync_quiet", sy_cnt, 0);
    check("data_bad",   data_bad, 0);
    check("timeouts",   timeouts, 0);

    // Spurious window_valid while idle
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    repeat (4) cyc();
    check("sync_spurious", sy_cnt, SY_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
